// File: rtl/vid_timing_gen.sv
// Camera-style video timing generator: vsync/href/clken framing, x/y coordinates, linear pixel index, frame counter.
// Latency: every framing output is one register stage after the hcnt/vcnt/state counter state, all mutually aligned.
// Backpressure: none; once launched a frame free-runs at one counter step per clock. Optional VID_TPG_PATTERN_EN adds a test pattern.
module vid_timing_gen #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_SYNC    = 5,
  parameter int H_BACK    = 5,
  parameter int H_FRONT   = 5,
  parameter int V_SYNC    = 1,
  parameter int V_BACK    = 0,
  parameter int V_FRONT   = 1,
  parameter int CNT_W     = 11,
  parameter int IDX_W     = 20,
  parameter int FCNT_W    = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic              mode_single,
  input  logic              start,
`ifdef VID_TPG_PATTERN_EN
  input  logic [1:0]        pat_sel,
  output logic [23:0]       pix_data,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [CNT_W-1:0]  x_pos,
  output logic [CNT_W-1:0]  y_pos,
  output logic [IDX_W-1:0]  pix_index,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + IMG_HDISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + IMG_VDISP + V_FRONT;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_LO   = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_HI   = CNT_W'(H_SYNC + H_BACK + IMG_HDISP);
  localparam logic [CNT_W-1:0] V_ACT_LO   = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_HI   = CNT_W'(V_SYNC + V_BACK + IMG_VDISP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Counter state
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   vcnt_q, vcnt_d;
  logic               single_q, single_d;
  logic [IDX_W-1:0]   pix_cnt_q, pix_cnt_d;

  // Registered outputs
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               vsync_q, vsync_d;
  logic               href_q, href_d;
  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

  // Decoded view of the current counter state
  logic               running;
  logic               frame_end;
  logic               active;
  logic [CNT_W-1:0]   x_cur;
  logic [CNT_W-1:0]   y_cur;

  // Decode where the counters currently sit within the frame.
  always_comb begin
    running   = (state_q != ST_IDLE);
    frame_end = running && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    active    = running &&
                (vcnt_q >= V_ACT_LO) && (vcnt_q < V_ACT_HI) &&
                (hcnt_q >= H_ACT_LO) && (hcnt_q < H_ACT_HI);
    x_cur     = hcnt_q - H_ACT_LO;
    y_cur     = vcnt_q - V_ACT_LO;
  end

  // Run-mode FSM and raster counters; a frame, once begun, always reaches its end.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    single_d = single_q;
    case (state_q)
      ST_IDLE: begin
        if (mode_single ? start : enable) begin
          state_d  = ST_RUN;
          single_d = mode_single;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          // Continuous with enable still high rolls straight into the next frame.
          if (single_q || !enable) begin
            state_d = ST_IDLE;
          end
        end else if (!single_q && !enable) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // enable is deliberately not looked at here; only IDLE may relaunch.
        if (frame_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!running) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_W'(1);
    end else begin
      hcnt_d = hcnt_q + CNT_W'(1);
    end
  end

  // Linear pixel index kept as a running count so no multiplier is needed.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (!running || frame_end) begin
      pix_cnt_d = '0;
    end else if (active) begin
      pix_cnt_d = pix_cnt_q + IDX_W'(1);
    end
  end

  // Next values of the framing outputs, derived only from the current counter state.
  always_comb begin
    busy_d       = running;
    frame_done_d = frame_end;
    vsync_d      = running && (vcnt_q >= V_SYNC_END);
    href_d       = active;
    x_d          = active ? x_cur : '0;
    y_d          = active ? y_cur : '0;
    idx_d        = active ? pix_cnt_q : '0;
    fcnt_d       = frame_end ? fcnt_q + FCNT_W'(1) : fcnt_q;
  end

  // State, counters and output registers; reset aborts any frame in flight.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      single_q     <= 1'b0;
      pix_cnt_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      idx_q        <= '0;
      fcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      single_q     <= single_d;
      pix_cnt_q    <= pix_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      x_q          <= x_d;
      y_q          <= y_d;
      idx_q        <= idx_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign post_frame_vsync = vsync_q;
  assign post_frame_href  = href_q;
  assign post_frame_clken = href_q;
  assign x_pos            = x_q;
  assign y_pos            = y_q;
  assign pix_index        = idx_q;
  assign frame_cnt        = fcnt_q;

`ifdef VID_TPG_PATTERN_EN
  // Bar width; the last bar absorbs any remainder so it reaches the line end.
  localparam int BAR_W = (IMG_HDISP / 8 > 0) ? IMG_HDISP / 8 : 1;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [1:0]       pat_q, pat_d;
  logic [2:0]       bar_q, bar_d;
  logic [CNT_W-1:0] bar_pos_q, bar_pos_d;
  logic [23:0]      pdat_q, pdat_d;
  logic [7:0]       fc8;
  logic [7:0]       x8;

  function automatic logic [23:0] bar_color(input logic [2:0] b);
    logic [23:0] c;
    case (b)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Pattern select is captured while idle and at each frame end, so it is stable for a whole frame.
  always_comb begin
    pat_d = pat_q;
    if (!running || frame_end) begin
      pat_d = pat_sel;
    end
  end

  // Colour-bar position tracked incrementally along the line instead of dividing x_pos.
  always_comb begin
    bar_d     = bar_q;
    bar_pos_d = bar_pos_q;
    if (!active) begin
      bar_d     = '0;
      bar_pos_d = '0;
    end else if ((bar_pos_q == BAR_LAST) && (bar_q != 3'd7)) begin
      bar_d     = bar_q + 3'd1;
      bar_pos_d = '0;
    end else begin
      bar_pos_d = bar_pos_q + CNT_W'(1);
    end
  end

  // Pixel colour for the current counter position, zero outside the active region.
  always_comb begin
    fc8    = 8'(fcnt_q);
    x8     = 8'(x_cur);
    pdat_d = 24'h000000;
    if (active) begin
      case (pat_q)
        2'd0:    pdat_d = bar_color(bar_q);
        2'd1:    pdat_d = {x8, x8, x8};
        2'd2:    pdat_d = (x_cur[3] ^ y_cur[3]) ? 24'hFFFFFF : 24'h000000;
        default: pdat_d = {fc8, fc8, fc8};
      endcase
    end
  end

  // Pattern registers, aligned with href.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pat_q     <= 2'd0;
      bar_q     <= 3'd0;
      bar_pos_q <= '0;
      pdat_q    <= 24'h000000;
    end else begin
      pat_q     <= pat_d;
      bar_q     <= bar_d;
      bar_pos_q <= bar_pos_d;
      pdat_q    <= pdat_d;
    end
  end

  assign pix_data = pdat_q;
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen on an 8x4 raster (14x6 totals, 84 cycles per frame) with a 2-bit frame counter.
// Pixels and frame_done events are queued as expected transactions when a frame is launched.
// A negedge monitor pops and compares them as the DUT emits them.
module tb_vid_timing_gen;

  localparam int HD = 8;
  localparam int VD = 4;
  localparam int CW = 11;
  localparam int IW = 20;
  localparam int FW = 2;
  localparam int FRAME = 84;

  typedef struct { int x; int y; int idx; } pix_t;
  typedef struct { int cyc; int fc; } fd_t;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic mode_single;
  logic start;
  logic busy;
  logic frame_done;
  logic vsync;
  logic href;
  logic clken;
  logic [CW-1:0] x_pos;
  logic [CW-1:0] y_pos;
  logic [IW-1:0] pix_index;
  logic [FW-1:0] frame_cnt;
`ifdef VID_TPG_PATTERN_EN
  logic [1:0]  pat_sel = 2'd0;
  logic [23:0] pix_data;
`endif

  pix_t pix_q[$];
  fd_t  fd_q[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   exp_fc = 0;
  int   vs_low = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vid_timing_gen #(
    .IMG_HDISP(HD), .IMG_VDISP(VD), .H_SYNC(2), .H_BACK(2), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(0), .V_FRONT(1), .CNT_W(CW), .IDX_W(IW), .FCNT_W(FW)
  ) u_dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .enable(enable),
    .mode_single(mode_single),
    .start(start),
`ifdef VID_TPG_PATTERN_EN
    .pat_sel(pat_sel),
    .pix_data(pix_data),
`endif
    .busy(busy),
    .frame_done(frame_done),
    .post_frame_vsync(vsync),
    .post_frame_href(href),
    .post_frame_clken(clken),
    .x_pos(x_pos),
    .y_pos(y_pos),
    .pix_index(pix_index),
    .frame_cnt(frame_cnt)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue one full frame of expected pixels plus its frame_done event.
  task automatic push_frame(input int done_cyc);
    for (int y = 0; y < VD; y++) begin
      for (int x = 0; x < HD; x++) begin
        pix_q.push_back('{x: x, y: y, idx: y * HD + x});
      end
    end
    exp_fc = (exp_fc + 1) % (1 << FW);
    fd_q.push_back('{cyc: done_cyc, fc: exp_fc});
  endtask

  task automatic launch_single();
    @(negedge clk);
    mode_single = 1'b1;
    start = 1'b1;
    push_frame(cyc + FRAME + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((fd_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk_val(tag, 32'(fd_q.size() != 0 || busy), 32'd0);
  endtask

  task automatic wait_pix(input int idx, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(href && 32'(pix_index) == idx) && n < budget);
    chk_val("wait_pix", 32'(href && 32'(pix_index) == idx), 32'd1);
  endtask

  // Output monitor: compares every emitted pixel and frame_done against the queues.
  always @(negedge clk) begin
    pix_t e;
    fd_t  f;
    if (!rst) begin
      chk_val("clken_eq_href", 32'(clken), 32'(href));
      if (href) begin
        if (pix_q.size() == 0) begin
          chk_val("pix_extra", 32'd1, 32'd0);
        end else begin
          e = pix_q.pop_front();
          chk_val("x_pos", 32'(x_pos), e.x);
          chk_val("y_pos", 32'(y_pos), e.y);
          chk_val("pix_index", 32'(pix_index), e.idx);
        end
      end else begin
        chk_val("zero_outside", 32'(x_pos != 0 || y_pos != 0 || pix_index != 0), 32'd0);
      end
      if (!busy) begin
        chk_val("vsync_idle", 32'(vsync), 32'd0);
        vs_low = 0;
      end else if (!vsync) begin
        vs_low++;
      end
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          chk_val("fd_extra", 32'd1, 32'd0);
        end else begin
          f = fd_q.pop_front();
          chk_val("fd_cycle", cyc, f.cyc);
          chk_val("frame_cnt", 32'(frame_cnt), f.fc);
          chk_val("vsync_low", vs_low, 32'd14);
        end
        vs_low = 0;
      end
    end
  end

  initial begin
    int c;
    int n;
    rst = 1'b1;
    enable = 1'b0;
    mode_single = 1'b0;
    start = 1'b0;

    // Reset state; launch requests during reset must be ignored.
    repeat (2) @(negedge clk);
    start = 1'b1;
    enable = 1'b1;
    mode_single = 1'b1;
    repeat (3) @(negedge clk);
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_href", 32'(href), 32'd0);
    chk_val("rst_vsync", 32'(vsync), 32'd0);
    chk_val("rst_fd", 32'(frame_done), 32'd0);
    chk_val("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk_val("rst_idx", 32'(pix_index), 32'd0);
    start = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_val("post_rst_busy", 32'(busy), 32'd0);

    // Single frame, with a stray start while busy.
    launch_single();
    repeat (30) @(negedge clk);
    chk_val("single_busy", 32'(busy), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("single_drain", 200);
    repeat (20) @(negedge clk);
    chk_val("single_left", pix_q.size(), 32'd0);
    chk_val("single_busy_after", 32'(busy), 32'd0);
    chk_val("single_fcnt", 32'(frame_cnt), 32'd1);

    // Continuous: three back-to-back frames, stop requested during the third.
    @(negedge clk);
    mode_single = 1'b0;
    enable = 1'b1;
    c = cyc;
    for (int k = 0; k < 3; k++) push_frame(c + FRAME + 1 + k * FRAME);
    n = 0;
    while (fd_q.size() > 1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk_val("cont_two_done", 32'(fd_q.size() <= 1), 32'd1);
    enable = 1'b0;
    wait_drain("cont_drain", 200);
    repeat (20) @(negedge clk);
    chk_val("cont_left", pix_q.size(), 32'd0);
    chk_val("cont_fcnt_wrap", 32'(frame_cnt), 32'd0);

    // Graceful stop at pixel 10; enable re-raised inside DRAIN must not add a frame.
    @(negedge clk);
    enable = 1'b1;
    push_frame(cyc + FRAME + 1);
    wait_pix(10, 200);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_drain("stop_drain", 200);
    repeat (40) @(negedge clk);
    chk_val("stop_left", pix_q.size(), 32'd0);
    chk_val("stop_busy", 32'(busy), 32'd0);
    chk_val("stop_fcnt", 32'(frame_cnt), 32'd1);

    // Reset in the middle of a frame aborts it immediately.
    launch_single();
    wait_pix(20, 200);
    rst = 1'b1;
    #1;
    chk_val("abort_href", 32'(href), 32'd0);
    chk_val("abort_clken", 32'(clken), 32'd0);
    chk_val("abort_pos", 32'(x_pos != 0 || y_pos != 0 || pix_index != 0), 32'd0);
    chk_val("abort_vsync", 32'(vsync), 32'd0);
    chk_val("abort_busy", 32'(busy), 32'd0);
    chk_val("abort_fcnt", 32'(frame_cnt), 32'd0);
    pix_q.delete();
    fd_q.delete();
    exp_fc = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk_val("abort_idle_busy", 32'(busy), 32'd0);
    launch_single();
    wait_drain("restart_drain", 200);
    chk_val("restart_fcnt", 32'(frame_cnt), 32'd1);

    // Frame counter wrap over five single frames, each with an ignored start while busy.
    @(negedge clk);
    rst = 1'b1;
    exp_fc = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      launch_single();
      repeat (25) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_drain("wrap_drain", 200);
      repeat (3) @(negedge clk);
    end
    chk_val("wrap_left", pix_q.size(), 32'd0);
    chk_val("wrap_fcnt", 32'(frame_cnt), 32'd1);

`ifdef VID_TPG_PATTERN_EN
    pat_run();
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

`ifdef VID_TPG_PATTERN_EN
  // Full-size instance for the test-pattern checks.
  logic          p_rst = 1'b1;
  logic          p_start = 1'b0;
  logic [1:0]    p_pat = 2'd0;
  logic          p_busy;
  logic          p_fd;
  logic          p_vs;
  logic          p_href;
  logic          p_clken;
  logic [10:0]   p_x;
  logic [10:0]   p_y;
  logic [19:0]   p_idx;
  logic [15:0]   p_fc;
  logic [23:0]   p_dat;

  vid_timing_gen u_pat (
    .sys_clk(clk), .sys_rst(p_rst), .enable(1'b0), .mode_single(1'b1), .start(p_start),
    .pat_sel(p_pat), .pix_data(p_dat), .busy(p_busy), .frame_done(p_fd),
    .post_frame_vsync(p_vs), .post_frame_href(p_href), .post_frame_clken(p_clken),
    .x_pos(p_x), .y_pos(p_y), .pix_index(p_idx), .frame_cnt(p_fc)
  );

  task automatic pat_launch(input logic [1:0] sel);
    @(negedge clk);
    p_rst = 1'b1;
    p_pat = sel;
    @(negedge clk);
    p_rst = 1'b0;
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
  endtask

  task automatic pat_run();
    int n;
    logic seen;
    pat_launch(2'd0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20000) begin
      @(negedge clk);
      n++;
      if (p_href && p_y == 11'd0) begin
        if (p_x == 11'd0)   chk_val("bar_x0", 32'(p_dat), 32'hFFFFFF);
        if (p_x == 11'd80)  chk_val("bar_x80", 32'(p_dat), 32'hFFFF00);
        if (p_x == 11'd639) begin
          chk_val("bar_x639", 32'(p_dat), 32'h000000);
          seen = 1'b1;
        end
      end
    end
    chk_val("bar_reached", 32'(seen), 32'd1);
    pat_launch(2'd2);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20000) begin
      @(negedge clk);
      n++;
      if (p_href && p_x == 11'd8 && p_y == 11'd0) chk_val("chk_8_0", 32'(p_dat), 32'hFFFFFF);
      if (p_href && p_x == 11'd8 && p_y == 11'd8) begin
        chk_val("chk_8_8", 32'(p_dat), 32'h000000);
        seen = 1'b1;
      end
    end
    chk_val("chk_reached", 32'(seen), 32'd1);
    @(negedge clk);
    p_rst = 1'b1;
  endtask
`endif

endmodule
